detector_monitor: RTL and testbench

- Stream sink for the detector video path. Consumes the single-pixel-per-beat stream produced by the detector pattern/background source.
- Checks frame framing and size, and measures pixel statistics and frame period.
- Exposes results to the CPU through an Avalon-MM read/write slave.
- Sits at the far end of the stream, or taps it in parallel. It never back-pressures: there is no ready signal.

---
 rtl/detector_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_detector_monitor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_monitor.sv
// Stream sink for the detector video path: checks SOP/EOP framing and frame size,
// measures per-frame pixel statistics and SOP-to-SOP period, exposes results over Avalon-MM.
module detector_monitor #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned EXP_WIDTH  = 384,
  parameter int unsigned EXP_HEIGHT = 288
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  input  logic [2:0]            av_address,
  input  logic                  av_read,
  output logic [31:0]           av_readdata,
  input  logic                  av_write,
  input  logic [31:0]           av_writedata
);

  localparam logic [31:0] EXP_PIXELS = 32'(EXP_WIDTH * EXP_HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, IN_FRAME} state_t;

  state_t r_state, w_state_n;

  logic r_enable, r_err_orphan, r_err_dup, r_err_size;
  logic r_result_valid, r_have_period, r_seen_sop;
  logic [31:0] r_cnt, r_sum, r_frame_cnt, r_period, r_last_period;
  logic [31:0] r_last_count, r_last_sum;
  logic [DATA_WIDTH-1:0] r_min, r_max, r_last_min, r_last_max;

  logic w_wr_ctrl, w_clear, w_hold, w_enable_rise;
  logic w_start, w_accum, w_commit, w_orphan, w_dup;
  logic [31:0] w_cnt_n, w_sum_n, w_rdata;
  logic [DATA_WIDTH-1:0] w_min_n, w_max_n;
  logic w_unused_wdata;

  assign w_unused_wdata = ^av_writedata[31:2];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // A control write that clears, disables, or first enables owns the cycle; any beat is dropped.
  always_comb begin
    w_state_n     = r_state;
    w_start       = 1'b0;
    w_accum       = 1'b0;
    w_commit      = 1'b0;
    w_orphan      = 1'b0;
    w_dup         = 1'b0;
    w_wr_ctrl     = av_write && (av_address == 3'd0);
    w_clear       = w_wr_ctrl && av_writedata[1];
    w_enable_rise = w_wr_ctrl && av_writedata[0] && !av_writedata[1] && (r_state == IDLE);
    w_hold        = w_clear || (w_wr_ctrl && (!av_writedata[0] || (r_state == IDLE)));
    if (w_hold) begin
      w_state_n = (w_wr_ctrl && av_writedata[0]) ? WAIT_SOP : IDLE;
    end else if (din_valid) begin
      unique case (r_state)
        WAIT_SOP: begin
          if (din_startofpacket) begin
            w_start   = 1'b1;
            w_commit  = din_endofpacket;
            w_state_n = din_endofpacket ? WAIT_SOP : IN_FRAME;
          end else begin
            w_orphan = 1'b1;
          end
        end
        IN_FRAME: begin
          if (din_startofpacket) begin
            w_dup     = 1'b1;
            w_start   = 1'b1;
            w_commit  = din_endofpacket;
            w_state_n = din_endofpacket ? WAIT_SOP : IN_FRAME;
          end else begin
            w_accum  = 1'b1;
            w_commit = din_endofpacket;
            if (din_endofpacket) w_state_n = WAIT_SOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (w_start) begin
      w_cnt_n = 32'd1;
      w_sum_n = 32'(din_data);
      w_min_n = din_data;
      w_max_n = din_data;
    end else begin
      w_cnt_n = sat_inc(r_cnt);
      w_sum_n = sat_add(r_sum, 32'(din_data));
      w_min_n = (din_data < r_min) ? din_data : r_min;
      w_max_n = (din_data > r_max) ? din_data : r_max;
    end
  end

  always_comb begin
    unique case (av_address)
      3'd0:    w_rdata = {25'd0, r_have_period, r_result_valid, r_err_size, r_err_dup,
                          r_err_orphan, (r_state == IN_FRAME), r_enable};
      3'd1:    w_rdata = r_frame_cnt;
      3'd2:    w_rdata = r_last_count;
      3'd3:    w_rdata = r_last_sum;
      3'd4:    w_rdata = {16'(r_last_max), 16'(r_last_min)};
      3'd5:    w_rdata = r_last_period;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      av_readdata    <= '0;
      r_enable       <= 1'b0;
      r_err_orphan   <= 1'b0;
      r_err_dup      <= 1'b0;
      r_err_size     <= 1'b0;
      r_result_valid <= 1'b0;
      r_have_period  <= 1'b0;
      r_seen_sop     <= 1'b0;
      r_cnt          <= '0;
      r_sum          <= '0;
      r_min          <= '0;
      r_max          <= '0;
      r_frame_cnt    <= '0;
      r_period       <= '0;
      r_last_period  <= '0;
      r_last_count   <= '0;
      r_last_sum     <= '0;
      r_last_min     <= '0;
      r_last_max     <= '0;
    end else begin
      r_state <= w_state_n;
      if (av_read) av_readdata <= w_rdata;
      if (w_wr_ctrl) r_enable <= av_writedata[0];
      if (w_clear) begin
        r_err_orphan   <= 1'b0;
        r_err_dup      <= 1'b0;
        r_err_size     <= 1'b0;
        r_result_valid <= 1'b0;
        r_have_period  <= 1'b0;
        r_seen_sop     <= 1'b0;
        r_cnt          <= '0;
        r_sum          <= '0;
        r_min          <= '0;
        r_max          <= '0;
        r_frame_cnt    <= '0;
        r_period       <= '0;
        r_last_period  <= '0;
        r_last_count   <= '0;
        r_last_sum     <= '0;
        r_last_min     <= '0;
        r_last_max     <= '0;
      end else begin
        if (w_start || w_accum) begin
          r_cnt <= w_cnt_n;
          r_sum <= w_sum_n;
          r_min <= w_min_n;
          r_max <= w_max_n;
        end
        if (w_commit) begin
          r_last_count   <= w_cnt_n;
          r_last_sum     <= w_sum_n;
          r_last_min     <= w_min_n;
          r_last_max     <= w_max_n;
          r_frame_cnt    <= sat_inc(r_frame_cnt);
          r_result_valid <= 1'b1;
          if (w_cnt_n != EXP_PIXELS) r_err_size <= 1'b1;
        end
        if (w_orphan) r_err_orphan <= 1'b1;
        if (w_dup)    r_err_dup    <= 1'b1;
        // Period restarts on every enable so it never spans an idle gap.
        if (w_enable_rise) begin
          r_seen_sop <= 1'b0;
          r_period   <= '0;
        end else if (w_start) begin
          if (r_seen_sop) begin
            r_last_period <= r_period;
            r_have_period <= 1'b1;
          end
          r_period   <= 32'd1;
          r_seen_sop <= 1'b1;
        end else if (r_state != IDLE) begin
          r_period <= sat_inc(r_period);
        end
      end
    end
  end

endmodule

// File: tb/tb_detector_monitor.sv
// Self-checking bench for detector_monitor: randomized frames against a frame-level
// queue model that derives statistics and SOP spacing from the bench's own stimulus.
module tb_detector_monitor;

  localparam int unsigned DW  = 10;
  localparam int unsigned EXP = 16 * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [DW-1:0] din_data = '0;
  logic        din_valid = 1'b0;
  logic        din_startofpacket = 1'b0;
  logic        din_endofpacket = 1'b0;
  logic [2:0]  av_address = '0;
  logic        av_read = 1'b0;
  logic [31:0] av_readdata;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = '0;

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;

  // Reference model state
  bit          m_enable, m_in, m_orphan, m_dup, m_size, m_rv, m_have_period;
  int unsigned m_frame_cnt, m_last_count, m_last_sum, m_last_min, m_last_max, m_last_period;
  int          m_prev_sop;
  int unsigned m_px[$];

  detector_monitor #(.DATA_WIDTH(DW), .EXP_WIDTH(16), .EXP_HEIGHT(8)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid),
    .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
    .av_address(av_address), .av_read(av_read), .av_readdata(av_readdata),
    .av_write(av_write), .av_writedata(av_writedata)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_enable = 0; m_in = 0; m_orphan = 0; m_dup = 0; m_size = 0; m_rv = 0; m_have_period = 0;
    m_frame_cnt = 0; m_last_count = 0; m_last_sum = 0; m_last_min = 0; m_last_max = 0;
    m_last_period = 0; m_prev_sop = -1; m_px.delete();
  endfunction

  function automatic void model_clear(input bit en);
    model_reset();
    m_enable = en;
  endfunction

  function automatic void model_commit();
    int unsigned s, mn, mx;
    s = 0; mn = m_px[0]; mx = m_px[0];
    foreach (m_px[i]) begin
      s += m_px[i];
      if (m_px[i] < mn) mn = m_px[i];
      if (m_px[i] > mx) mx = m_px[i];
    end
    m_last_count = m_px.size(); m_last_sum = s; m_last_min = mn; m_last_max = mx;
    m_frame_cnt++; m_rv = 1;
    if (m_px.size() != EXP) m_size = 1;
    m_in = 0; m_px.delete();
  endfunction

  function automatic void model_beat(input int unsigned d, input bit s, input bit e, input int c);
    if (s) begin
      if (m_in) m_dup = 1;
      if (m_prev_sop >= 0) begin
        m_last_period = c - m_prev_sop;
        m_have_period = 1;
      end
      m_prev_sop = c;
      m_px.delete();
      m_px.push_back(d);
      m_in = 1;
    end else if (!m_in) begin
      m_orphan = 1;
      return;
    end else begin
      m_px.push_back(d);
    end
    if (e) model_commit();
  endfunction

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0: return {25'd0, m_have_period, m_rv, m_size, m_dup, m_orphan, m_in, m_enable};
      1: return m_frame_cnt;
      2: return m_last_count;
      3: return m_last_sum;
      4: return {m_last_max[15:0], m_last_min[15:0]};
      5: return m_last_period;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic beat(input int unsigned d, input bit s, input bit e, input bit v);
    int c;
    din_data = d[DW-1:0]; din_valid = v; din_startofpacket = s; din_endofpacket = e;
    c = tcyc;
    tick();
    din_valid = 0; din_startofpacket = 0; din_endofpacket = 0;
    if (v && m_enable) model_beat(d, s, e, c);
  endtask

  task automatic frame(input int len, input bit rnd, input int unsigned val);
    for (int i = 0; i < len; i++)
      beat(rnd ? $urandom_range(0, 1023) : val, i == 0, i == len - 1, 1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    av_address = a; av_writedata = d; av_write = 1;
    tick();
    av_write = 0;
    if (a == 3'd0) begin
      if (d[1]) model_clear(d[0]);
      else if (!d[0]) begin m_enable = 0; m_in = 0; m_px.delete(); end
      else if (!m_enable) begin m_enable = 1; m_prev_sop = -1; end
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    av_address = a; av_read = 1;
    tick();
    av_read = 0;
    v = av_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1; tick(); tick(); rst = 0;
    model_reset();
    total++;
    if (av_readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata: got %h want 0", av_readdata); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_reg addr%0d: got %h want 0", a, v); end
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] v;
    wr(0, 32'h1);
    for (int i = 0; i < int'(EXP); i++) beat(i % 1024, i == 0, i == int'(EXP) - 1, 1);
    rd(2, v); total++;
    if (v !== EXP) begin bad++; $display("FAIL full_count: got %0d want %0d", v, EXP); end
    rd(1, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL full_frame_cnt: got %0d want 1", v); end
    rd(4, v); total++;
    if (v !== {16'd127, 16'd0}) begin bad++; $display("FAIL full_minmax: got %h want %h", v, {16'd127, 16'd0}); end
    rd(0, v); total++;
    if (v !== 32'h21) begin bad++; $display("FAIL full_status: got %h want 21", v); end
  endtask

  task automatic test_random_frames();
    logic [31:0] v;
    for (int f = 0; f < 8; f++) begin
      int gap, len;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) beat($urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      len = ($urandom_range(0, 1) == 1) ? int'(EXP) : $urandom_range(1, 160);
      frame(len, 1, 0);
      for (int a = 0; a < 8; a++) begin
        rd(3'(a), v); total++;
        if (v !== exp_reg(a)) begin bad++; $display("FAIL random_f%0d addr%0d: got %h want %h", f, a, v, exp_reg(a)); end
      end
    end
  endtask

  task automatic test_constant_frame();
    logic [31:0] v;
    wr(0, 32'h3);
    frame(100, 0, 7);
    rd(2, v); total++;
    if (v !== 32'd100) begin bad++; $display("FAIL const_count: got %0d want 100", v); end
    rd(3, v); total++;
    if (v !== 32'd700) begin bad++; $display("FAIL const_sum: got %0d want 700", v); end
    rd(4, v); total++;
    if (v !== 32'h00070007) begin bad++; $display("FAIL const_minmax: got %h want 00070007", v); end
    rd(1, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL const_frame_cnt: got %0d want 1", v); end
    rd(0, v); total++;
    if (v !== 32'h31) begin bad++; $display("FAIL const_status: got %h want 31", v); end
  endtask

  task automatic test_orphan_dup();
    logic [31:0] v;
    wr(0, 32'h3);
    for (int i = 0; i < 5; i++) beat($urandom_range(0, 1023), 0, $urandom_range(0, 1), 1);
    for (int i = 0; i < 50; i++) beat($urandom_range(0, 1023), i == 0, 0, 1);
    frame(10, 1, 0);
    rd(2, v); total++;
    if (v !== 32'd10) begin bad++; $display("FAIL dup_count: got %0d want 10", v); end
    rd(1, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL dup_frame_cnt: got %0d want 1", v); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== exp_reg(a)) begin bad++; $display("FAIL dup_reg addr%0d: got %h want %h", a, v, exp_reg(a)); end
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] v;
    wr(0, 32'h3);
    beat(5, 1, 1, 1);
    rd(2, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", v); end
    rd(4, v); total++;
    if (v !== 32'h00050005) begin bad++; $display("FAIL single_minmax: got %h want 00050005", v); end
    rd(0, v); total++;
    if (v[1] !== 1'b0) begin bad++; $display("FAIL single_in_frame: got %b want 0", v[1]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(0, 32'h3);
    for (int i = 0; i < 5; i++) beat($urandom_range(0, 1023), 1, 1, 1);
    rd(5, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL b2b_period: got %0d want 1", v); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== exp_reg(a)) begin bad++; $display("FAIL b2b_reg addr%0d: got %h want %h", a, v, exp_reg(a)); end
    end
  endtask

  task automatic test_read_during_update();
    logic [31:0] v, old;
    int c;
    frame(3, 1, 0);
    for (int i = 0; i < 3; i++) beat($urandom_range(0, 1023), i == 0, 0, 1);
    old = m_frame_cnt;
    din_data = 10'd9; din_valid = 1; din_endofpacket = 1;
    av_address = 3'd1; av_read = 1;
    c = tcyc;
    tick();
    din_valid = 0; din_endofpacket = 0; av_read = 0;
    model_beat(9, 0, 1, c);
    total++;
    if (av_readdata !== old) begin bad++; $display("FAIL rd_same_cycle: got %0d want %0d", av_readdata, old); end
    rd(1, v); total++;
    if (v !== old + 1) begin bad++; $display("FAIL rd_after_update: got %0d want %0d", v, old + 1); end
  endtask

  task automatic test_clear_on_eop();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) beat($urandom_range(0, 1023), i == 0, 0, 1);
    din_data = 10'd3; din_valid = 1; din_endofpacket = 1;
    av_address = 3'd0; av_writedata = 32'h3; av_write = 1;
    tick();
    din_valid = 0; din_endofpacket = 0; av_write = 0;
    model_clear(1);
    rd(1, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL clear_frame_cnt: got %0d want 0", v); end
    rd(0, v); total++;
    if (v !== 32'h1) begin bad++; $display("FAIL clear_status: got %h want 1", v); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== exp_reg(a)) begin bad++; $display("FAIL clear_reg addr%0d: got %h want %h", a, v, exp_reg(a)); end
    end
  endtask

  task automatic test_disable_mid_frame();
    logic [31:0] v;
    frame(20, 1, 0);
    for (int i = 0; i < 5; i++) beat($urandom_range(0, 1023), i == 0, 0, 1);
    wr(0, 32'h0);
    frame(10, 1, 0);
    beat(1, 0, 0, 1);
    rd(2, v); total++;
    if (v !== 32'd20) begin bad++; $display("FAIL disable_count: got %0d want 20", v); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== exp_reg(a)) begin bad++; $display("FAIL disable_reg addr%0d: got %h want %h", a, v, exp_reg(a)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    wr(0, 32'h1);
    frame(6, 1, 0);
    for (int i = 0; i < 7; i++) beat($urandom_range(0, 1023), i == 0, 0, 1);
    rd(1, v);
    rst = 1; tick(); rst = 0;
    model_reset();
    total++;
    if (av_readdata !== 32'd0) begin bad++; $display("FAIL rst_mid_readdata: got %h want 0", av_readdata); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rst_mid_reg addr%0d: got %h want 0", a, v); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    test_constant_frame();
    test_orphan_dup();
    test_single_beat();
    test_back_to_back();
    test_read_during_update();
    test_clear_on_eop();
    test_disable_mid_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
